ref_particle_prefetcher: RTL

REF_PARTICLE_PREFETCHER -- requirements
Module: ref_particle_prefetcher

---
 rtl/ref_particle_prefetcher_if.sv | 45 ++++
 rtl/ref_particle_prefetcher.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ref_particle_prefetcher_if.sv
// Reference-particle prefetcher bus: broadcast input side + FIFO head output side.
// slave = prefetcher, master = broadcaster/consumer.
interface ref_particle_prefetcher_if #(
  parameter int OFFSET_WIDTH      = 29,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int DATA_WIDTH        = OFFSET_WIDTH + CELL_ID_WIDTH,
  parameter int PARTICLE_ID_WIDTH = 7
);
  logic                         start;
  logic                         phase;
  logic                         in_valid;
  logic                         in_is_count;
  logic [OFFSET_WIDTH-1:0]      raw_pos_x;
  logic [OFFSET_WIDTH-1:0]      raw_pos_y;
  logic [OFFSET_WIDTH-1:0]      raw_pos_z;
  logic [PARTICLE_ID_WIDTH-1:0] particle_id;
  logic                         ref_ready;
  logic                         ref_valid;
  logic [DATA_WIDTH-1:0]        ref_x;
  logic [DATA_WIDTH-1:0]        ref_y;
  logic [DATA_WIDTH-1:0]        ref_z;
  logic [PARTICLE_ID_WIDTH-1:0] ref_id;
  logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count;
  logic                         busy;
  logic                         done;
  logic                         ovf_err;

  modport slave (
    input  start, phase, in_valid, in_is_count,
    input  raw_pos_x, raw_pos_y, raw_pos_z,
    input  particle_id, ref_ready,
    output ref_valid, ref_x, ref_y, ref_z,
    output ref_id, ref_particle_count,
    output busy, done, ovf_err
  );

  modport master (
    output start, phase, in_valid, in_is_count,
    output raw_pos_x, raw_pos_y, raw_pos_z,
    output particle_id, ref_ready,
    input  ref_valid, ref_x, ref_y, ref_z,
    input  ref_id, ref_particle_count,
    input  busy, done, ovf_err
  );
endinterface

// File: rtl/ref_particle_prefetcher.sv
// Captures broadcast particles in ascending-ID order into a small FIFO.
// Ports: clk, rst (async high), bus (slave modport of ref_particle_prefetcher_if).
module ref_particle_prefetcher #(
  parameter int OFFSET_WIDTH      = 29,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int DATA_WIDTH        = OFFSET_WIDTH + CELL_ID_WIDTH,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int DEPTH             = 4,
  parameter logic [CELL_ID_WIDTH-1:0] CELL_P1_X = 3'b001,
  parameter logic [CELL_ID_WIDTH-1:0] CELL_P1_Y = 3'b001,
  parameter logic [CELL_ID_WIDTH-1:0] CELL_P1_Z = 3'b001,
  parameter logic [CELL_ID_WIDTH-1:0] CELL_P0_X = 3'b010,
  parameter logic [CELL_ID_WIDTH-1:0] CELL_P0_Y = 3'b010,
  parameter logic [CELL_ID_WIDTH-1:0] CELL_P0_Z = 3'b010
) (
  input logic clk,
  input logic rst,
  ref_particle_prefetcher_if.slave bus
);
  localparam int IW = PARTICLE_ID_WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DATA_WIDTH != OFFSET_WIDTH + CELL_ID_WIDTH) begin : g_bad_dw
    $error("DATA_WIDTH must equal OFFSET_WIDTH + CELL_ID_WIDTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (OFFSET_WIDTH < PARTICLE_ID_WIDTH) begin : g_bad_cnt
    $error("count field does not fit in raw_pos_x");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_FILL, S_DRAIN, S_DONE
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;
  logic [IW-1:0]   cap_id;
  logic [IW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            ovf_q;

  logic [DATA_WIDTH-1:0] mem_x [DEPTH];
  logic [DATA_WIDTH-1:0] mem_y [DEPTH];
  logic [DATA_WIDTH-1:0] mem_z [DEPTH];
  logic [IW-1:0]         mem_id [DEPTH];

  logic empty, full, match, push, drop, pop, last;
  logic [CELL_ID_WIDTH-1:0] cell_x, cell_y, cell_z;

  assign empty = (occ == '0);
  assign full  = (occ == CW'(DEPTH));
  assign match = (state_q == S_FILL) && bus.in_valid &&
                 !bus.in_is_count &&
                 (bus.particle_id == cap_id);
  // start wins over any same-cycle capture
  assign push  = match && !full && !bus.start;
  assign drop  = match && full && !bus.start;
  assign pop   = !empty && bus.ref_ready;
  assign last  = (bus.particle_id == cnt_q - IW'(1));

  assign cell_x = bus.phase ? CELL_P1_X : CELL_P0_X;
  assign cell_y = bus.phase ? CELL_P1_Y : CELL_P0_Y;
  assign cell_z = bus.phase ? CELL_P1_Z : CELL_P0_Z;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr]  <= {cell_x, bus.raw_pos_x};
      mem_y[wr_ptr]  <= {cell_y, bus.raw_pos_y};
      mem_z[wr_ptr]  <= {cell_z, bus.raw_pos_z};
      mem_id[wr_ptr] <= bus.particle_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      cap_id  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.start) begin
      state_q <= S_COUNT;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      cap_id  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        cap_id <= cap_id + IW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push && !pop: occ <= occ + CW'(1);
        pop && !push: occ <= occ - CW'(1);
        default: ;
      endcase
      if (drop) ovf_q <= 1'b1;
      unique case (state_q)
        S_COUNT: begin
          if (bus.in_valid && bus.in_is_count) begin
            cnt_q  <= bus.raw_pos_x[IW-1:0];
            cap_id <= '0;
            if (bus.raw_pos_x[IW-1:0] == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (push && last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (empty) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // head is gated so an empty FIFO presents all-zero data
  assign bus.ref_valid = !empty;
  assign bus.ref_x     = empty ? '0 : mem_x[rd_ptr];
  assign bus.ref_y     = empty ? '0 : mem_y[rd_ptr];
  assign bus.ref_z     = empty ? '0 : mem_z[rd_ptr];
  assign bus.ref_id    = empty ? '0 : mem_id[rd_ptr];
  assign bus.ref_particle_count = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf_err   = ovf_q;
endmodule
